// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store front-end of the data RAM.
package mem_access_pkg;

   localparam int unsigned DEF_DATA_BUS_WIDTH = 16;
   localparam int unsigned DEF_ADDR_WIDTH     = 12;
   localparam int unsigned BYTE_WIDTH         = 8;

   // Byte lane select values for req_hi
   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_e;

   // Latched control fields of an accepted request
   typedef struct packed {
      logic we;
      logic byte_acc;
      logic hi;
      logic sgn;
   } req_ctrl_t;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte lane helper: extract/extend a lane for loads, merge a byte for stores.
// Only present when MEM_ACCESS_BYTE_EN is defined.
`ifdef MEM_ACCESS_BYTE_EN
module mem_byte_lane
   import mem_access_pkg::*;
#(
   parameter int unsigned DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH
) (
   input  logic [DATA_BUS_WIDTH-1:0] rd_word,
   input  logic                      lane_hi,
   input  logic                      sign_ext,
   input  logic [BYTE_WIDTH-1:0]     wr_byte,
   output logic [DATA_BUS_WIDTH-1:0] load_word_c,
   output logic [DATA_BUS_WIDTH-1:0] merge_word_c
);

   localparam int unsigned EXT_WIDTH = DATA_BUS_WIDTH - BYTE_WIDTH;

   logic [BYTE_WIDTH-1:0] lane_c;

   // Select the addressed lane and extend it into a full word
   always_comb begin
      lane_c      = rd_word[BYTE_WIDTH-1:0];
      if (lane_hi == LANE_HI) begin
         lane_c = rd_word[2*BYTE_WIDTH-1:BYTE_WIDTH];
      end
      load_word_c = {{EXT_WIDTH{sign_ext & lane_c[BYTE_WIDTH-1]}}, lane_c};
   end

   // Replace the addressed lane, keep the rest of the word
   always_comb begin
      merge_word_c = rd_word;
      if (lane_hi == LANE_HI) begin
         merge_word_c[2*BYTE_WIDTH-1:BYTE_WIDTH] = wr_byte;
      end else begin
         merge_word_c[BYTE_WIDTH-1:0] = wr_byte;
      end
   end

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// Load/store front-end driving a word-only synchronous RAM.
// Byte loads and read-modify-write byte stores exist when MEM_ACCESS_BYTE_EN
// is defined; otherwise every access is a word access.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int unsigned DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
   parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic                      req_byte,
   input  logic                      req_hi,
   input  logic                      req_signed,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [DATA_BUS_WIDTH-1:0] resp_rdata,
   output logic [DATA_BUS_WIDTH-1:0] mem_address,
   output logic [DATA_BUS_WIDTH-1:0] mem_write_data,
   output logic                      mem_read_not_write,
   output logic                      mem_cs,
   input  logic [DATA_BUS_WIDTH-1:0] mem_read_data
);

   state_e state;
   logic   byte_req_c;

`ifdef MEM_ACCESS_BYTE_EN
   req_ctrl_t             ctrl_q;
   logic [BYTE_WIDTH-1:0] wbyte_q;
   logic [DATA_BUS_WIDTH-1:0] lane_load_c;
   logic [DATA_BUS_WIDTH-1:0] merge_word_c;
   logic [DATA_BUS_WIDTH-1:0] load_word_c;

   assign byte_req_c  = req_byte;
   assign load_word_c = ctrl_q.byte_acc ? lane_load_c : mem_read_data;

   // Latch the byte-access fields of an accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= '0;
         wbyte_q <= '0;
      end else if (state == IDLE && req_valid && req_ready) begin
         ctrl_q  <= '{we: req_we, byte_acc: req_byte, hi: req_hi, sgn: req_signed};
         wbyte_q <= req_wdata[BYTE_WIDTH-1:0];
      end
   end

   mem_byte_lane #(
      .DATA_BUS_WIDTH (DATA_BUS_WIDTH)
   ) u_byte_lane (
      .rd_word      (mem_read_data),
      .lane_hi      (ctrl_q.hi),
      .sign_ext     (ctrl_q.sgn),
      .wr_byte      (wbyte_q),
      .load_word_c  (lane_load_c),
      .merge_word_c (merge_word_c)
   );
`else
   logic unused_byte_fields;

   assign byte_req_c         = 1'b0;
   assign unused_byte_fields = ^{req_byte, req_hi, req_signed};
`endif

   // Access sequencer; every RAM pin and response output is a flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         req_ready          <= 1'b1;
         resp_valid         <= 1'b0;
         resp_rdata         <= '0;
         mem_cs             <= 1'b0;
         mem_read_not_write <= 1'b1;
         mem_address        <= '0;
         mem_write_data     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready   <= 1'b0;
                  mem_cs      <= 1'b1;
                  mem_address <= DATA_BUS_WIDTH'(req_addr);
                  if (req_we && !byte_req_c) begin
                     state              <= WR;
                     mem_read_not_write <= 1'b0;
                     mem_write_data     <= req_wdata;
                  end else begin
                     state              <= RD;
                     mem_read_not_write <= 1'b1;
                  end
               end
            end
            RD: begin
               // RAM registers the word at this edge; data is visible in CAP
               state  <= CAP;
               mem_cs <= 1'b0;
            end
            CAP: begin
`ifdef MEM_ACCESS_BYTE_EN
               if (ctrl_q.we) begin
                  state              <= WR;
                  mem_cs             <= 1'b1;
                  mem_read_not_write <= 1'b0;
                  mem_write_data     <= merge_word_c;
               end else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= load_word_c;
               end
`else
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_rdata <= mem_read_data;
`endif
            end
            WR: begin
               state              <= RESP;
               mem_cs             <= 1'b0;
               mem_read_not_write <= 1'b1;
               resp_valid         <= 1'b1;
               resp_rdata         <= '0;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state              <= IDLE;
               req_ready          <= 1'b1;
               resp_valid         <= 1'b0;
               mem_cs             <= 1'b0;
               mem_read_not_write <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store front-end that sits directly upstream of the data RAM.
- Accepts one CPU memory request at a time over a valid/ready handshake and drives the RAM's address, write-data, read_not_write and cs pins.
- Captures the RAM's one-cycle registered read data and returns it over a valid/ready response channel.
- Implements byte stores as read-modify-write, because the RAM is 16-bit-word-only, little-endian: low byte = bits[7:0].

Parameters:
- DATA_BUS_WIDTH, 16, width of RAM data/address pins and CPU data.
- ADDR_WIDTH, 12, significant word-address bits; zero-extended to DATA_BUS_WIDTH on mem_address.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_hi  in  1  byte lane select; 1 = bits[15:8]; ignored for word access.
- req_signed  in  1  sign-extend byte loads; ignored otherwise.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_BUS_WIDTH  store data; byte stores use bits[7:0].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_BUS_WIDTH  load result; 0 for stores.
- mem_address  out  DATA_BUS_WIDTH  to RAM address.
- mem_write_data  out  DATA_BUS_WIDTH  to RAM write_data.
- mem_read_not_write  out  1  to RAM read_not_write.
- mem_cs  out  1  to RAM cs.
- mem_read_data  in  DATA_BUS_WIDTH  from RAM read_data; valid the cycle after a read cs cycle, Z otherwise.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, mem_cs=0, mem_read_not_write=1, mem_address=0, mem_write_data=0, and all latched request fields 0.
- FSM states: IDLE, RD, CAP, WR, RESP. Outputs are decoded from registered state and latched fields:
  - req_ready = (state==IDLE).
  - mem_cs = (state==RD or WR).
  - mem_read_not_write = (state!=WR).
- IDLE:
  - On req_valid&req_ready, latch all req_* fields.
  - Go to WR if it is a word store, otherwise go to RD.
- RD: one cycle with cs=1 and rnw=1 at the latched address; go to CAP.
- CAP:
  - Sample mem_read_data at the end of this cycle; cs=0.
  - Load: form the result, go to RESP.
  - Byte store: merge req_wdata[7:0] into the selected lane, keep the other lane, go to WR.
- WR: one cycle with cs=1, rnw=0, mem_write_data = store word; go to RESP.
- RESP: resp_valid=1 and resp_rdata held stable until resp_ready; on the handshake go to IDLE.
- Latency from the accept edge to resp_valid high:
  - word store: 2 cycles.
  - load (word or byte): 3 cycles.
  - byte store: 4 cycles.
- Back-to-back: the next request is accepted no earlier than the cycle after the response handshake; there is no overlap.
- Byte load: the selected lane goes to resp_rdata[7:0]; the upper bits are zero-filled, or copies of bit 7 when req_signed=1.
- Word access: req_hi and req_signed are ignored.
- Store response: resp_rdata=0.
- mem_cs is asserted for exactly one cycle per RAM access, never in consecutive cycles for a read followed by its capture.
- Address: mem_address = {zeros, latched req_addr}; the top address ADDR_WIDTH'h FFF is legal, with no wrap logic.
- Request inputs are ignored outside IDLE.
- Reset mid-operation: cs drops immediately and the FSM returns to IDLE. A write already clocked into the RAM stands; no response is generated.
- resp_ready held high while entering RESP: the handshake completes on the first RESP edge.

Optional Feature:
- Macro: MEM_ACCESS_BYTE_EN.
- Defined: byte loads/stores with RMW as above.
- Undefined:
  - req_byte, req_hi and req_signed are ignored.
  - Every access is a word access; the CAP→WR path is absent.
  - Byte-store latency does not exist.

Decomposition:
- Package mem_access_pkg holds: the state encodings (IDLE, RD, CAP, WR, RESP), the DATA_BUS_WIDTH/ADDR_WIDTH defaults, and the lane select constants LANE_LO/LANE_HI.
- One natural combinational sub-module, mem_byte_lane, handles lane extract with zero/sign extension for loads and lane merge for stores.
- mem_byte_lane is instantiated only under MEM_ACCESS_BYTE_EN.

Test Plan:
- Reset check: assert rst_n=0 mid-RD → mem_cs=0 immediately; after release, req_ready=1 and resp_valid=0.
- Word load: RAM word 16 = 0x0014, load addr 16 with resp_ready=1 → mem_cs high for exactly 1 cycle, resp_valid at cycle 3, resp_rdata=0x0014.
- Word store then load: store 0xBEEF to addr 48, then load addr 48 → store response at cycle 2 with resp_rdata=0; load returns 0xBEEF.
- Byte store, high lane: RAM word 2 = 0x0002, byte store 0x00AB with req_hi=1 → RD, CAP, WR sequence; RAM word 2 = 0xAB02, response at cycle 4.
- Signed byte load: RAM word 8 holds 0x0080, low lane:
  - req_signed=1 → resp_rdata=0xFF80.
  - req_signed=0 → resp_rdata=0x0080.
- Response backpressure: hold resp_ready=0 for 5 cycles during a load of addr 1 → resp_valid and resp_rdata=0x0001 stay stable, req_ready=0, no further mem_cs; release → IDLE next cycle.
